// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet header capture path.
package eth_parser_pkg;

    localparam int unsigned HDR_BYTES     = 18;
    localparam int unsigned MIN_HDR_BYTES = 14;
    localparam int unsigned LEN_W         = 16;

    typedef logic [47:0] mac_addr_t;
    typedef logic [15:0] ethertype_t;

    typedef struct packed {
        mac_addr_t  dst;
        mac_addr_t  src;
        ethertype_t etype;
    } eth_ii_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HDR        = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_PARSE = 3'd3,
        ST_PAYLOAD    = 3'd4,
        ST_DRAIN      = 3'd5
    } cap_state_e;

    // Byte counter increment that sticks at all-ones.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == '1) ? v : v + LEN_W'(1);
    endfunction

endpackage

// File: rtl/eth_hdr_shift_reg.sv
// Header byte-slot capture: byte 0 lands in the top byte, later slots are
// written by index, and a new frame zero-fills everything but byte 0.
module eth_hdr_shift_reg #(
    parameter int unsigned HDR_BYTES = 18
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         wr_en,
    input  logic [$clog2(HDR_BYTES)-1:0] slot,
    input  logic [7:0]                   din,
    output logic [HDR_BYTES*8-1:0]       header_bytes
);
    import eth_parser_pkg::*;

    localparam int unsigned IDX_W = $clog2(HDR_BYTES);

    logic [HDR_BYTES-1:0][7:0] slots_q;
    logic [IDX_W-1:0]          pos;

    // Slot n sits at packed index HDR_BYTES-1-n so byte 0 is the MSB byte.
    assign pos = IDX_W'(HDR_BYTES - 1) - slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q <= '0;
        end else if (start) begin
            slots_q                <= '0;
            slots_q[HDR_BYTES-1]   <= din;
        end else if (wr_en) begin
            slots_q[pos] <= din;
        end
    end

    assign header_bytes = slots_q;

endmodule

// File: rtl/eth_hdr_capture_ctrl.sv
// Ingress frame controller: captures the header window, hands it to the
// parser, then passes or drains the payload and reports length and errors.
module eth_hdr_capture_ctrl #(
    parameter int unsigned HDR_BYTES     = eth_parser_pkg::HDR_BYTES,
    parameter int unsigned PARSE_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_last,
    output logic [HDR_BYTES*8-1:0] header_bytes,
    output logic                   header_valid,
    input  logic                   fields_valid,
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic [15:0]            frame_len,
    output logic                   frame_len_valid,
    output logic                   err_runt,
    output logic                   err_timeout,
    output logic                   busy
);
    import eth_parser_pkg::*;

    localparam int unsigned IDX_W = $clog2(HDR_BYTES);
    localparam int unsigned TMO_W = $clog2(PARSE_TIMEOUT + 1);

    cap_state_e       state_q, state_d;
    logic             active_q;
    logic [LEN_W-1:0] count_q, count_d;
    logic             ended_q, ended_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             xfer, last_xfer, in_payload;
    logic             runt_d, tmo_err_d;
    logic             cap_start, cap_wr;

    // active_q keeps s_ready low while reset is held and for the release edge.
    always_comb begin
        s_ready = 1'b0;
        if (active_q) begin
            case (state_q)
                ST_IDLE, ST_HDR, ST_DRAIN: s_ready = 1'b1;
                ST_PAYLOAD:                s_ready = m_ready;
                default:                   s_ready = 1'b0;
            endcase
        end
    end

    assign xfer       = s_valid & s_ready;
    assign last_xfer  = xfer & s_last;
    assign in_payload = (state_q == ST_PAYLOAD);
    assign m_valid    = in_payload & s_valid;
    assign m_last     = in_payload & s_last;
    assign m_data     = in_payload ? s_data : 8'h00;

    // Next-state, counters and pulse requests.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ended_d   = ended_q;
        tmo_d     = '0;
        runt_d    = 1'b0;
        tmo_err_d = 1'b0;
        cap_start = 1'b0;
        cap_wr    = 1'b0;

        if (xfer) begin
            count_d = (state_q == ST_IDLE) ? LEN_W'(1) : sat_inc(count_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    cap_start = 1'b1;
                    ended_d   = 1'b0;
                    if (s_last) runt_d  = 1'b1;
                    else        state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    cap_wr = 1'b1;
                    if (s_last && (count_d < LEN_W'(MIN_HDR_BYTES))) begin
                        runt_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (s_last || (count_d == LEN_W'(HDR_BYTES))) begin
                        ended_d = s_last;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // The issue cycle itself counts toward the parse budget.
                tmo_d   = TMO_W'(1);
                state_d = ST_WAIT_PARSE;
            end
            ST_WAIT_PARSE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (fields_valid) begin
                    state_d = ended_q ? ST_IDLE : ST_PAYLOAD;
                end else if (tmo_q >= TMO_W'(PARSE_TIMEOUT - 1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = ended_q ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_PAYLOAD, ST_DRAIN: begin
                if (last_xfer) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            active_q        <= 1'b0;
            count_q         <= '0;
            ended_q         <= 1'b0;
            tmo_q           <= '0;
            header_valid    <= 1'b0;
            frame_len       <= '0;
            frame_len_valid <= 1'b0;
            err_runt        <= 1'b0;
            err_timeout     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            active_q        <= 1'b1;
            count_q         <= count_d;
            ended_q         <= ended_d;
            tmo_q           <= tmo_d;
            header_valid    <= (state_d == ST_ISSUE);
            frame_len_valid <= last_xfer;
            err_runt        <= runt_d;
            err_timeout     <= tmo_err_d;
            busy            <= (state_d != ST_IDLE);
            if (last_xfer) frame_len <= count_d;
        end
    end

    eth_hdr_shift_reg #(
        .HDR_BYTES (HDR_BYTES)
    ) u_shift (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (cap_start),
        .wr_en        (cap_wr),
        .slot         (count_q[IDX_W-1:0]),
        .din          (s_data),
        .header_bytes (header_bytes)
    );

endmodule

// File: doc/eth_hdr_capture_ctrl.md
ETH_HDR_CAPTURE_CTRL -- requirements
Module: eth_hdr_capture_ctrl

Interface
REQ-001 Parameter HDR_BYTES, default 18, header window in bytes (14-byte Ethernet II header plus 4-byte VLAN tag).
REQ-002 Parameter PARSE_TIMEOUT, default 4, cycles allowed for fields_valid after header_valid.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_data  input  8  ingress frame byte.
REQ-006 s_valid / s_ready / s_last  in/out/in  1 each  ingress handshake; s_last marks the final byte.
REQ-007 header_bytes  output  HDR_BYTES*8  captured header; byte 0 in bits [HDR_BYTES*8-1 -: 8].
REQ-008 header_valid  output  1  one-cycle pulse to the header parser.
REQ-009 fields_valid  input  1  parser completion.
REQ-010 m_data / m_valid / m_ready / m_last  out/out/in/out  8/1/1/1  egress payload stream.
REQ-011 frame_len / frame_len_valid  output  16/1  total accepted frame bytes, with a one-cycle pulse.
REQ-012 err_runt / err_timeout  output  1 each  one-cycle error pulses.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, HDR, ISSUE, WAIT_PARSE, PAYLOAD, DRAIN.
REQ-015 Byte transfers occur only when s_valid && s_ready; a byte counter increments on each transfer and saturates at 16'hFFFF.
REQ-016 IDLE: s_ready=1; the first transfer stores byte 0, clears the rest of header_bytes to 0, sets count=1 and moves to HDR (s_last on that byte is a runt).
REQ-017 HDR: s_ready=1; byte n is stored at byte slot n; the state leaves after byte HDR_BYTES-1 or on s_last.
REQ-018 s_last with count < 14 is a runt: pulse err_runt, no header_valid, return to IDLE.
REQ-019 s_last with count 14..HDR_BYTES leaves the unfilled slots zero and goes to ISSUE, with the "frame ended" flag set.
REQ-020 ISSUE: s_ready=0; header_valid=1 for exactly this cycle; next state is WAIT_PARSE.
REQ-021 WAIT_PARSE: s_ready=0; fields_valid received within PARSE_TIMEOUT cycles goes to PAYLOAD, or to IDLE if the frame-ended flag is set.
REQ-022 On timeout in WAIT_PARSE, pulse err_timeout and go to DRAIN, or to IDLE if the frame-ended flag is set.
REQ-023 fields_valid arriving in the same cycle as the timeout expiry counts as success.
REQ-024 PAYLOAD: combinational pass-through with m_data=s_data, m_valid=s_valid, m_last=s_last, s_ready=m_ready; a transfer with s_last returns to IDLE.
REQ-025 DRAIN: s_ready=1, m_valid=0; bytes are discarded; s_last returns to IDLE.
REQ-026 frame_len_valid pulses with frame_len=count on the cycle after the final byte of any frame, including runt and drained frames.
REQ-027 fields_valid outside WAIT_PARSE is ignored.
REQ-028 header_bytes holds its value from ISSUE until the next frame's byte 0.
REQ-029 m_valid=0 outside PAYLOAD.

Reset
REQ-030 Asserting rst_n low at any time forces IDLE asynchronously and aborts any frame mid-operation without error pulses.
REQ-031 Reset values: s_ready=0 while in reset; all data, length, header, valid and error outputs 0; count 0; frame-ended flag 0; timeout counter 0.
REQ-032 The first frame after reset deasserts is accepted from IDLE.

Structure
REQ-033 HDR_BYTES, the minimum header length (14), the state enum type and the existing mac_addr_t/ethertype_t typedefs live in eth_parser_pkg.
REQ-034 One sub-module, eth_hdr_shift_reg, SHALL perform byte-slot capture and zero-fill; the FSM, counters and pass-through stay in the top.

Verification
REQ-035 Bench with a behavioural parser returning fields_valid 1 cycle after header_valid; send a 64-byte frame starting FF FF FF FF FF FF 00 11 22 33 44 55 08 00. Required: header_valid pulses once; header_bytes[143:112]=32'hFFFFFFFF; bytes 12-13 are 08 00; 46 bytes appear on m_* with m_last on the last; frame_len=64.
REQ-036 Send a 10-byte frame. Required: err_runt pulse, no header_valid, frame_len=10, busy=0 afterwards.
REQ-037 Send a 15-byte frame. Required: header_valid pulses; slots 15-17 are 00; no m_valid; frame_len=15.
REQ-038 Hold fields_valid low on a 40-byte frame. Required: err_timeout pulses 4 cycles after header_valid; the remaining 22 bytes are drained with m_valid=0; frame_len=40.
REQ-039 Toggle m_ready with a 1-on/1-off pattern in PAYLOAD. Required: s_ready tracks m_ready, with no byte lost or duplicated.
REQ-040 Pull rst_n low at byte 20 of a frame. Required: outputs return to 0 immediately; the next frame parses correctly.
